motion_deskew_stream: RTL and testbench

Streaming, pipelined successor to the combinational motion corrector. It de-skews LiDAR points by computing c = p − α·vT per point, where α is derived in hardware from the point timestamp and a per-frame reciprocal scan time. It runs on a valid/ready point stream with backpressure and loads velocity-offset configuration per frame through a shadow register. It sits between the point-cloud ingest FIFO and the downstream voxel/export stage.

---
 rtl/mc_pkg.sv | 32 +++
 rtl/mc_axis_correct.sv | 55 +++++
 rtl/motion_deskew_stream.sv | 185 ++++++++++++++++++
 tb/tb_motion_deskew_stream.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and helpers for the motion de-skew pipeline: Q16.16 point type,
// per-frame configuration record and signed saturation.
package mc_pkg;

   localparam int          MC_WP     = 32;
   localparam int          FRAC      = 16;
   localparam logic [31:0] ALPHA_ONE = 32'h4000_0000;

   typedef logic signed [MC_WP-1:0] q16_t;

   typedef struct packed {
      q16_t        vT_x;
      q16_t        vT_y;
      q16_t        vT_z;
      logic [31:0] inv_t;
   } mc_cfg_t;

   // Clamp a wide signed intermediate into the signed point range.
   function automatic q16_t sat_s(input logic signed [65:0] v);
      logic signed [65:0] hi;
      logic signed [65:0] lo;
      hi = $signed({{(67-MC_WP){1'b0}}, {(MC_WP-1){1'b1}}});
      lo = -hi - 66'sd1;
      if (v > hi)
         return hi[MC_WP-1:0];
      else if (v < lo)
         return lo[MC_WP-1:0];
      else
         return v[MC_WP-1:0];
   endfunction

endpackage

// File: rtl/mc_axis_correct.sv
// One axis of the de-skew datapath: offset = alpha * vT (stage 2) and
// corrected point = p - offset (stage 3), both with rounding/saturation.
module mc_axis_correct
   import mc_pkg::*;
#(
   parameter int WP = 32,
   parameter int AW = 32
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [AW-1:0] alpha,
   input  logic [WP-1:0] vt,
   input  logic [WP-1:0] p,
   output logic [WP-1:0] c
);

   localparam int            PW   = AW + WP + 1;
   localparam int            SH   = AW - 2;
   localparam logic [PW-1:0] HALF = {{(PW-1){1'b0}}, 1'b1} << (SH - 1);

   logic signed [PW-1:0] off_full;
   logic signed [PW-1:0] off_rnd;
   logic signed [65:0]   off_w;
   logic signed [WP:0]   diff;
   logic signed [65:0]   diff_w;
   q16_t                 off_p1;
   logic [WP-1:0]        p_p1;

   always_comb begin
      // alpha is unsigned, so it enters the signed multiply zero-extended
      off_full = $signed({{WP{1'b0}}, 1'b0, alpha}) * $signed({{(AW+1){vt[WP-1]}}, vt});
      off_rnd  = off_full + $signed(HALF);
      off_w    = $signed({off_rnd[PW-1], off_rnd}) >>> SH;
      diff     = $signed({p_p1[WP-1], p_p1}) - $signed({off_p1[WP-1], off_p1});
      diff_w   = $signed({{(65-WP){diff[WP]}}, diff});
   end

   // stage 2 -> stage 3 boundary
   always_ff @(posedge clk) begin
      if (en) begin
         off_p1 <= sat_s(off_w);
         p_p1   <= p;
      end
   end

   // stage 3 -> output boundary
   always_ff @(posedge clk) begin
      if (rst)
         c <= '0;
      else if (en)
         c <= sat_s(diff_w);
   end

endmodule

// File: rtl/motion_deskew_stream.sv
// Streaming LiDAR de-skew: c = p - alpha*vT, alpha = dt * inv_T, 3-stage pipeline
// with global stall. Optional alpha clamp to [0,1.0] under MC_ALPHA_CLAMP_EN.
module motion_deskew_stream
   import mc_pkg::*;
#(
   parameter int WP    = 32,
   parameter int FRAC  = 16,
   parameter int AW    = 32,
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   input  logic [WP-1:0]    cfg_vT_x,
   input  logic [WP-1:0]    cfg_vT_y,
   input  logic [WP-1:0]    cfg_vT_z,
   input  logic [31:0]      cfg_inv_t,
   output logic             cfg_pending,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WP-1:0]    in_px,
   input  logic [WP-1:0]    in_py,
   input  logic [WP-1:0]    in_pz,
   input  logic [31:0]      in_dt,
   input  logic             in_sof,
   input  logic             in_eof,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WP-1:0]    out_cx,
   output logic [WP-1:0]    out_cy,
   output logic [WP-1:0]    out_cz,
   output logic             out_sof,
   output logic             out_eof,
   output logic [CNT_W-1:0] clamp_cnt
);

   localparam int RSH = 2*FRAC - (AW - 2);

   logic          en;
   logic          accept;
   logic          accept_sof;
   mc_cfg_t       shadow;
   mc_cfg_t       active;
   mc_cfg_t       new_cfg;
   mc_cfg_t       cur_cfg;
   logic [63:0]   prod;
   logic [64:0]   prod_rnd;
   logic [64:0]   alpha_full;
   logic [AW-1:0] alpha_sat;
   logic [AW-1:0] alpha_s1;

   logic          vld_p0, vld_p1, vld_p2;
   logic          sof_p0, sof_p1, sof_p2;
   logic          eof_p0, eof_p1, eof_p2;
   logic [AW-1:0] alpha_p0;
   logic [WP-1:0] px_p0, py_p0, pz_p0;
   logic [WP-1:0] vtx_p0, vty_p0, vtz_p0;

   assign en         = !out_valid || out_ready;
   assign in_ready   = en;
   assign accept     = in_valid && en;
   assign accept_sof = accept && in_sof;

   assign new_cfg = '{vT_x: cfg_vT_x, vT_y: cfg_vT_y, vT_z: cfg_vT_z, inv_t: cfg_inv_t};

   // The sof point already sees the configuration it switches in.
   always_comb begin
      cur_cfg = active;
      if (accept_sof) begin
         if (cfg_valid)
            cur_cfg = new_cfg;
         else if (cfg_pending)
            cur_cfg = shadow;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow      <= '0;
         active      <= '0;
         cfg_pending <= 1'b0;
      end else begin
         if (cfg_valid)
            shadow <= new_cfg;
         if (accept_sof) begin
            active      <= cur_cfg;
            cfg_pending <= 1'b0;
         end else if (cfg_valid) begin
            cfg_pending <= 1'b1;
         end
      end
   end

   always_comb begin
      prod       = {32'b0, in_dt} * {32'b0, cur_cfg.inv_t};
      prod_rnd   = {1'b0, prod} + ({{64{1'b0}}, 1'b1} << (RSH - 1));
      alpha_full = prod_rnd >> RSH;
      alpha_sat  = (|alpha_full[64:AW]) ? '1 : alpha_full[AW-1:0];
   end

`ifdef MC_ALPHA_CLAMP_EN
   logic             clamped;
   logic [CNT_W-1:0] cnt;

   always_comb begin
      clamped  = alpha_sat > ALPHA_ONE;
      alpha_s1 = clamped ? ALPHA_ONE : alpha_sat;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (accept) begin
         if (in_sof)
            cnt <= {{(CNT_W-1){1'b0}}, clamped};
         else if (clamped && cnt != '1)
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign clamp_cnt = cnt;
`else
   assign alpha_s1  = alpha_sat;
   assign clamp_cnt = '0;
`endif

   // stage 1 -> stage 2 boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0 <= 1'b0;
         sof_p0 <= 1'b0;
         eof_p0 <= 1'b0;
      end else if (en) begin
         vld_p0 <= in_valid;
         sof_p0 <= in_valid && in_sof;
         eof_p0 <= in_valid && in_eof;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         alpha_p0 <= alpha_s1;
         px_p0    <= in_px;
         py_p0    <= in_py;
         pz_p0    <= in_pz;
         vtx_p0   <= cur_cfg.vT_x;
         vty_p0   <= cur_cfg.vT_y;
         vtz_p0   <= cur_cfg.vT_z;
      end
   end

   // stage 2 -> stage 3 -> output boundaries for the control flags
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         sof_p1 <= 1'b0;
         eof_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         sof_p2 <= 1'b0;
         eof_p2 <= 1'b0;
      end else if (en) begin
         vld_p1 <= vld_p0;
         sof_p1 <= sof_p0;
         eof_p1 <= eof_p0;
         vld_p2 <= vld_p1;
         sof_p2 <= sof_p1;
         eof_p2 <= eof_p1;
      end
   end

   assign out_valid = vld_p2;
   assign out_sof   = sof_p2;
   assign out_eof   = eof_p2;

   mc_axis_correct #(.WP(WP), .AW(AW)) u_x (
      .clk(clk), .rst(rst), .en(en), .alpha(alpha_p0), .vt(vtx_p0), .p(px_p0), .c(out_cx)
   );
   mc_axis_correct #(.WP(WP), .AW(AW)) u_y (
      .clk(clk), .rst(rst), .en(en), .alpha(alpha_p0), .vt(vty_p0), .p(py_p0), .c(out_cy)
   );
   mc_axis_correct #(.WP(WP), .AW(AW)) u_z (
      .clk(clk), .rst(rst), .en(en), .alpha(alpha_p0), .vt(vtz_p0), .p(pz_p0), .c(out_cz)
   );

endmodule

// File: tb/tb_motion_deskew_stream.sv
// Directed bench for motion_deskew_stream with an arithmetic reference model
// and an in-order scoreboard checked on every output transfer.
module tb_motion_deskew_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic [31:0] cfg_vT_x = '0, cfg_vT_y = '0, cfg_vT_z = '0, cfg_inv_t = '0;
   logic        cfg_pending;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_px = '0, in_py = '0, in_pz = '0, in_dt = '0;
   logic        in_sof = 1'b0, in_eof = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_cx, out_cy, out_cz;
   logic        out_sof, out_eof;
   logic [15:0] clamp_cnt;

   motion_deskew_stream dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_vT_x(cfg_vT_x), .cfg_vT_y(cfg_vT_y),
      .cfg_vT_z(cfg_vT_z), .cfg_inv_t(cfg_inv_t), .cfg_pending(cfg_pending),
      .in_valid(in_valid), .in_ready(in_ready), .in_px(in_px), .in_py(in_py), .in_pz(in_pz),
      .in_dt(in_dt), .in_sof(in_sof), .in_eof(in_eof), .out_valid(out_valid),
      .out_ready(out_ready), .out_cx(out_cx), .out_cy(out_cy), .out_cz(out_cz),
      .out_sof(out_sof), .out_eof(out_eof), .clamp_cnt(clamp_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] vx, vy, vz, inv; } mcfg_t;
   typedef struct { logic [31:0] cx, cy, cz; logic sof, eof; } exp_t;

   int    n_checks = 0;
   int    n_fail   = 0;
   exp_t  exp_q[$];
   mcfg_t m_sh, m_act;
   bit    m_pending;
   int    m_cnt;
   logic [31:0] last_cx, last_cy, last_cz;
   int    full_seen = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] m_sat(input logic signed [127:0] v);
      logic signed [127:0] r;
      r = v;
      if (v > 128'sh7FFF_FFFF) r = 128'sh7FFF_FFFF;
      if (v < -128'sh8000_0000) r = -128'sh8000_0000;
      return r[31:0];
   endfunction

   function automatic logic [31:0] m_alpha(input logic [31:0] dt, input logic [31:0] inv,
                                           output bit cl);
      logic [127:0] a;
      a  = ({96'b0, dt} * {96'b0, inv} + 128'd2) >> 2;
      if (a > 128'hFFFF_FFFF) a = 128'hFFFF_FFFF;
      cl = 1'b0;
`ifdef MC_ALPHA_CLAMP_EN
      if (a > 128'h4000_0000) begin
         a  = 128'h4000_0000;
         cl = 1'b1;
      end
`endif
      return a[31:0];
   endfunction

   function automatic logic [31:0] m_corr(input logic [31:0] p, input logic [31:0] alpha,
                                          input logic [31:0] vt);
      logic signed [127:0] off;
      logic signed [127:0] c;
      off = $signed({96'b0, alpha}) * $signed({{96{vt[31]}}, vt});
      off = (off + 128'sd536870912) >>> 30;
      off = $signed({{96{1'b0}}, m_sat(off)});
      off = $signed({{96{off[31]}}, off[31:0]});
      c   = $signed({{96{p[31]}}, p}) - off;
      return m_sat(c);
   endfunction

   task automatic model_accept(input logic [31:0] px, py, pz, dt, input logic sof, eof);
      exp_t        e;
      bit          cl;
      logic [31:0] a;
      if (sof) begin
         if (m_pending) m_act = m_sh;
         m_pending = 1'b0;
      end
      a = m_alpha(dt, m_act.inv, cl);
      if (sof) m_cnt = cl ? 1 : 0;
      else if (cl && m_cnt < 65535) m_cnt++;
      e.cx = m_corr(px, a, m_act.vx);
      e.cy = m_corr(py, a, m_act.vy);
      e.cz = m_corr(pz, a, m_act.vz);
      e.sof = sof;
      e.eof = eof;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      m_sh = '{0, 0, 0, 0};
      m_act = '{0, 0, 0, 0};
      m_pending = 1'b0;
      m_cnt = 0;
      exp_q.delete();
   endtask

   task automatic send(input logic [31:0] px, py, pz, dt, input logic sof, eof);
      bit acc = 1'b0;
      int budget = 100;
      in_valid = 1'b1; in_px = px; in_py = py; in_pz = pz; in_dt = dt;
      in_sof = sof; in_eof = eof;
      while (!acc && budget > 0) begin
         #1;
         acc = in_ready;
         @(posedge clk);
         if (acc) model_accept(px, py, pz, dt, sof, eof);
         @(negedge clk);
         budget--;
      end
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
   endtask

   task automatic cfg_load(input logic [31:0] vx, vy, vz, inv);
      cfg_valid = 1'b1; cfg_vT_x = vx; cfg_vT_y = vy; cfg_vT_z = vz; cfg_inv_t = inv;
      @(posedge clk);
      m_sh = '{vx, vy, vz, inv};
      m_pending = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic drain();
      int budget = 60;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   // scoreboard: every output transfer against the model, in order
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst && out_valid && !out_ready) begin
            full_seen++;
            chk("in_ready_stalled", 64'(in_ready), 64'd0);
         end
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_cx", 64'(out_cx), 64'(e.cx));
               chk("out_cy", 64'(out_cy), 64'(e.cy));
               chk("out_cz", 64'(out_cz), 64'(e.cz));
               chk("out_sof", 64'(out_sof), 64'(e.sof));
               chk("out_eof", 64'(out_eof), 64'(e.eof));
               last_cx = out_cx; last_cy = out_cy; last_cz = out_cz;
            end
         end
      end
   end

   initial begin
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_cfg_pending", 64'(cfg_pending), 64'd0);
      chk("rst_clamp_cnt", 64'(clamp_cnt), 64'd0);
      chk("rst_out_cx", 64'(out_cx), 64'd0);
      chk("rst_out_sof", 64'(out_sof), 64'd0);

      // unconfigured: alpha is zero, point passes through
      send(32'h0001_8000, 32'h0000_0005, 32'hFFFF_FFF9, 32'h1999, 1'b0, 1'b0);
      drain();
      chk("unconfigured_cx", 64'(last_cx), 64'h1_8000);

      // basic correction and 3-cycle latency
      cfg_load(32'h9999, 32'h0, 32'h0, 32'h5_0000);
      chk("pending_after_load", 64'(cfg_pending), 64'd1);
      send(32'h000A_0000, 32'h0003_0000, 32'hFFFE_0000, 32'h1999, 1'b1, 1'b0);
      chk("pending_after_sof", 64'(cfg_pending), 64'd0);
      chk("latency_c1", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("latency_c2", 64'(out_valid), 64'd0);
      @(negedge clk);
      chk("latency_c3", 64'(out_valid), 64'd1);
      drain();
      chk("basic_cx", 64'(last_cx), 64'd635701);
      chk("basic_cx_near", 64'((last_cx >= 32'h9B332) && (last_cx <= 32'h9B336)), 64'd1);
      chk("basic_cy", 64'(last_cy), 64'h3_0000);

      // shadow config: mid-frame load waits for the next sof
      cfg_load(32'h1_0000, 32'h0, 32'h0, 32'h5_0000);
      send(32'h000A_0000, 32'h0, 32'h0, 32'h1999, 1'b0, 1'b1);
      drain();
      chk("shadow_old_cx", 64'(last_cx), 64'd635701);
      chk("shadow_pending", 64'(cfg_pending), 64'd1);
      send(32'h000A_0000, 32'h0, 32'h0, 32'h1999, 1'b1, 1'b0);
      drain();
      chk("shadow_new_cx", 64'(last_cx), 64'd622595);
      chk("shadow_cleared", 64'(cfg_pending), 64'd0);

      // alpha = 1.5
      cfg_load(32'h9999, 32'h0, 32'h0, 32'h5_0000);
      send(32'h000A_0000, 32'h0, 32'h0, 32'h4CCD, 1'b1, 1'b0);
      drain();
`ifdef MC_ALPHA_CLAMP_EN
      chk("clamp_cx", 64'(last_cx), 64'd616039);
      chk("clamp_cnt_1", 64'(clamp_cnt), 64'd1);
`else
      chk("noclamp_cx", 64'(last_cx), 64'd596378);
      chk("clamp_cnt_off", 64'(clamp_cnt), 64'd0);
`endif
      send(32'h000A_0000, 32'h0, 32'h0, 32'h4CCD, 1'b0, 1'b0);
      send(32'h000A_0000, 32'h0, 32'h0, 32'h1000, 1'b0, 1'b1);
      drain();
      chk("clamp_cnt_model", 64'(clamp_cnt), 64'(m_cnt));

      // saturation at both ends of the signed range
      cfg_load(32'hFFFE_0000, 32'h0002_0000, 32'h0, 32'h1_0000);
      send(32'h7FFF_0000, 32'h8001_0000, 32'h0, 32'h1_0000, 1'b1, 1'b1);
      drain();
      chk("sat_hi_cx", 64'(last_cx), 64'h7FFF_FFFF);
      chk("sat_lo_cy", 64'(last_cy), 64'h8000_0000);

      // backpressure: 8 back-to-back points, output stalled 5 cycles
      cfg_load(32'h0000_4000, 32'hFFFF_3000, 32'h0001_2345, 32'h0002_8000);
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(32'h0001_0000 * i + 32'h123, 32'h8000_0000 + 32'h7_1111 * i,
                    32'h7FFF_F000 - 32'h3_0000 * i, 32'h2000 * i, (i == 0), (i == 7));
         end
         begin
            repeat (4) @(negedge clk);
            out_ready = 1'b0;
            repeat (5) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();
      chk("full_stall_seen", 64'(full_seen > 0), 64'd1);

      // reset mid-stream drops in-flight points
      send(32'h0005_0000, 32'h0, 32'h0, 32'h1000, 1'b1, 1'b0);
      send(32'h0006_0000, 32'h0, 32'h0, 32'h1000, 1'b0, 1'b0);
      cfg_valid = 1'b1; cfg_vT_x = 32'h1234;
      rst = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      model_reset();
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_pending", 64'(cfg_pending), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      send(32'h0002_8000, 32'h0, 32'h0, 32'h1999, 1'b1, 1'b1);
      drain();
      chk("post_rst_passthru", 64'(last_cx), 64'h2_8000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
